// File: rtl/morse_sym_timer_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse symbol timer.
//   state_e          : symbol FSM states (IDLE, ON, GAP, DONE)
//   DEF_*_UNITS      : default timing, in Morse time units
//   max4()           : largest of four integers, used to size the unit counter
// -----------------------------------------------------------------------------
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int DEF_DOT_UNITS      = 1;
    localparam int DEF_DASH_UNITS     = 3;
    localparam int DEF_SYM_GAP_UNITS  = 1;
    localparam int DEF_CHAR_GAP_UNITS = 3;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/morse_sym_timer_if.sv
// -----------------------------------------------------------------------------
// morse_sym_timer_if
// Symbol handshake between the character/code sequencer and the symbol timer.
//   sym_strt  : start request (sampled by the timer only while not busy)
//   symbol    : 0 = dot, 1 = dash (sampled with sym_strt)
//   sym_last  : symbol ends a character, use the inter-character gap
//   led_drv   : LED drive
//   sym_done  : one-cycle completion pulse
//   busy      : symbol in progress (ON or GAP)
// Modports: master = sequencer side, slave = timer side.
// -----------------------------------------------------------------------------
interface morse_sym_timer_if;

    logic sym_strt;
    logic symbol;
    logic sym_last;
    logic led_drv;
    logic sym_done;
    logic busy;

    modport master (
        output sym_strt,
        output symbol,
        output sym_last,
        input  led_drv,
        input  sym_done,
        input  busy
    );

    modport slave (
        input  sym_strt,
        input  symbol,
        input  sym_last,
        output led_drv,
        output sym_done,
        output busy
    );

endinterface

// File: rtl/morse_sym_timer_prescaler.sv
// -----------------------------------------------------------------------------
// morse_unit_prescaler
// Divides the clock into Morse time units. The count runs 0..UNIT_CYCLES-1 and
// unit_tick is high while the count sits at UNIT_CYCLES-1.
//   clock     : system clock
//   reset     : asynchronous, active-high
//   clr       : restart the count from 0 at the next edge
//   unit_tick : last clock cycle of the current time unit
// -----------------------------------------------------------------------------
module morse_unit_prescaler #(
    parameter int UNIT_CYCLES = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    output logic unit_tick
);

    localparam int PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam logic [PW-1:0] LAST_CNT = PW'(UNIT_CYCLES - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;

    assign unit_tick = (presc_q == LAST_CNT);

    always_comb begin
        presc_d = presc_q + PW'(1);
        if (clr || unit_tick) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/morse_sym_timer.sv
// -----------------------------------------------------------------------------
// morse_sym_timer
// Drives the Morse LED for one dot or dash per handshake, then holds the dark
// inter-symbol or inter-character gap and pulses sym_done.
//   clock  : system clock
//   reset  : asynchronous, active-high, forces IDLE immediately
//   sym_if : slave side of morse_sym_timer_if (sym_strt/symbol/sym_last in,
//            led_drv/sym_done/busy out, all outputs registered)
// Timing with acceptance at edge 0: led_drv high for N*UNIT_CYCLES cycles,
// dark for G*UNIT_CYCLES cycles, then sym_done for one cycle.
// -----------------------------------------------------------------------------
module morse_sym_timer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES    = 1,
    parameter int DOT_UNITS      = DEF_DOT_UNITS,
    parameter int DASH_UNITS     = DEF_DASH_UNITS,
    parameter int SYM_GAP_UNITS  = DEF_SYM_GAP_UNITS,
    parameter int CHAR_GAP_UNITS = DEF_CHAR_GAP_UNITS
) (
    input  logic               clock,
    input  logic               reset,
    morse_sym_timer_if.slave   sym_if
);

    generate
        if (UNIT_CYCLES < 1 || DOT_UNITS < 1 || DASH_UNITS < 1 ||
            SYM_GAP_UNITS < 0 || CHAR_GAP_UNITS < 0) begin : g_bad_params
            $error("morse_sym_timer: UNIT_CYCLES, DOT_UNITS and DASH_UNITS must be >= 1, gaps >= 0");
        end
    endgenerate

    localparam int CNT_W = $clog2(max4(DASH_UNITS, DOT_UNITS,
                                       CHAR_GAP_UNITS, SYM_GAP_UNITS) + 1);

    localparam logic [CNT_W-1:0] DOT_CNT      = CNT_W'(DOT_UNITS);
    localparam logic [CNT_W-1:0] DASH_CNT     = CNT_W'(DASH_UNITS);
    localparam logic [CNT_W-1:0] SYM_GAP_CNT  = CNT_W'(SYM_GAP_UNITS);
    localparam logic [CNT_W-1:0] CHAR_GAP_CNT = CNT_W'(CHAR_GAP_UNITS);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              led_drv_q, led_drv_d;
    logic              sym_done_q, sym_done_d;
    logic              busy_q, busy_d;

    logic              unit_tick;
    logic              presc_clr;
    logic [CNT_W-1:0]  gap_cnt;

    // Every state entry restarts the unit so each phase lasts whole units.
    morse_unit_prescaler #(
        .UNIT_CYCLES (UNIT_CYCLES)
    ) u_prescaler (
        .clock     (clock),
        .reset     (reset),
        .clr       (presc_clr),
        .unit_tick (unit_tick)
    );

    assign gap_cnt = last_q ? CHAR_GAP_CNT : SYM_GAP_CNT;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;

        case (state_q)
            // DONE accepts like IDLE so a held sym_strt chains symbols with
            // no idle bubble. The symbol itself is captured as the ON length
            // loaded into the counter; only sym_last is needed afterwards.
            IDLE, DONE: begin
                if (sym_if.sym_strt) begin
                    last_d  = sym_if.sym_last;
                    cnt_d   = sym_if.symbol ? DASH_CNT : DOT_CNT;
                    state_d = ON;
                end else begin
                    state_d = IDLE;
                end
            end

            ON: begin
                if (unit_tick) begin
                    if (cnt_q == CNT_ONE) begin
                        if (gap_cnt == '0) begin
                            cnt_d   = '0;
                            state_d = DONE;
                        end else begin
                            cnt_d   = gap_cnt;
                            state_d = GAP;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end

            GAP: begin
                if (unit_tick) begin
                    if (cnt_q == CNT_ONE) begin
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign presc_clr = (state_d != state_q);

    // Outputs are registered copies of the decode of the next state, so they
    // line up exactly with the state register.
    always_comb begin
        led_drv_d  = (state_d == ON);
        busy_d     = (state_d == ON) || (state_d == GAP);
        sym_done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= 1'b0;
            led_drv_q  <= 1'b0;
            sym_done_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            led_drv_q  <= led_drv_d;
            sym_done_q <= sym_done_d;
            busy_q     <= busy_d;
        end
    end

    assign sym_if.led_drv  = led_drv_q;
    assign sym_if.sym_done = sym_done_q;
    assign sym_if.busy     = busy_q;

endmodule

// File: tb/tb_morse_sym_timer.sv
// -----------------------------------------------------------------------------
// tb_morse_sym_timer
// Three timers: defaults (index 0), UNIT_CYCLES=4 (index 1) and
// SYM_GAP_UNITS=0 (index 2). Directed symbols with hand-derived waveforms.
// Cycle c is the clock period following edge c-1; acceptance happens at edge 0.
// -----------------------------------------------------------------------------
module tb_morse_sym_timer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic strt   [3];
    logic sym    [3];
    logic last   [3];
    logic led_o  [3];
    logic busy_o [3];
    logic done_o [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    morse_sym_timer_if if_def ();
    morse_sym_timer_if if_uc4 ();
    morse_sym_timer_if if_g0  ();

    assign if_def.sym_strt = strt[0];
    assign if_def.symbol   = sym[0];
    assign if_def.sym_last = last[0];
    assign if_uc4.sym_strt = strt[1];
    assign if_uc4.symbol   = sym[1];
    assign if_uc4.sym_last = last[1];
    assign if_g0.sym_strt  = strt[2];
    assign if_g0.symbol    = sym[2];
    assign if_g0.sym_last  = last[2];

    assign led_o[0]  = if_def.led_drv;
    assign busy_o[0] = if_def.busy;
    assign done_o[0] = if_def.sym_done;
    assign led_o[1]  = if_uc4.led_drv;
    assign busy_o[1] = if_uc4.busy;
    assign done_o[1] = if_uc4.sym_done;
    assign led_o[2]  = if_g0.led_drv;
    assign busy_o[2] = if_g0.busy;
    assign done_o[2] = if_g0.sym_done;

    morse_sym_timer u_def (
        .clock  (clk),
        .reset  (rst),
        .sym_if (if_def)
    );

    morse_sym_timer #(
        .UNIT_CYCLES (4)
    ) u_uc4 (
        .clock  (clk),
        .reset  (rst),
        .sym_if (if_uc4)
    );

    morse_sym_timer #(
        .SYM_GAP_UNITS (0)
    ) u_g0 (
        .clock  (clk),
        .reset  (rst),
        .sym_if (if_g0)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One symbol on timer d: n on-units, g gap-units, uc cycles per unit.
    // p != 0 raises sym_strt across edge p (while busy) to confirm it is ignored.
    // symbol/sym_last are inverted right after acceptance to confirm they are latched.
    task automatic play(input int d, input bit s, input bit l, input int n,
                        input int g, input int uc, input int p, input string name);
        int on_end;
        int busy_end;
        on_end   = n * uc;
        busy_end = (n + g) * uc;
        @(negedge clk);
        strt[d] = 1'b1;
        sym[d]  = s;
        last[d] = l;
        @(posedge clk);
        #1;
        strt[d] = 1'b0;
        sym[d]  = ~s;
        last[d] = ~l;
        for (int c = 1; c <= busy_end + 2; c++) begin
            @(negedge clk);
            chk($sformatf("%s c%0d led", name, c),  int'(led_o[d]),  int'(c <= on_end));
            chk($sformatf("%s c%0d busy", name, c), int'(busy_o[d]), int'(c <= busy_end));
            chk($sformatf("%s c%0d done", name, c), int'(done_o[d]), int'(c == busy_end + 1));
            if (p != 0 && c == p)     strt[d] = 1'b1;
            if (p != 0 && c == p + 1) strt[d] = 1'b0;
        end
        $display("sym %s: dut=%0d symbol=%0d last=%0d on=%0d gap=%0d cycles",
                 name, d, s, l, on_end, busy_end - on_end);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] e_led;
        logic [9:0] e_busy;
        logic [9:0] e_done;

        for (int i = 0; i < 3; i++) begin
            strt[i] = 1'b0;
            sym[i]  = 1'b0;
            last[i] = 1'b0;
        end

        // Reset state, checked before any clock edge.
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst%0d led", i),  int'(led_o[i]),  0);
            chk($sformatf("rst%0d busy", i), int'(busy_o[i]), 0);
            chk($sformatf("rst%0d done", i), int'(done_o[i]), 0);
        end
        $display("reset: initial output state checked");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Defaults.
        play(0, 1'b0, 1'b0, 1, 1, 1, 0, "def_dot");
        play(0, 1'b1, 1'b1, 3, 3, 1, 0, "def_dash_last");
        play(0, 1'b1, 1'b1, 3, 3, 1, 5, "def_dash_last_pulse_gap");
        play(0, 1'b1, 1'b0, 3, 1, 1, 2, "def_dash_pulse_on");
        play(0, 1'b0, 1'b1, 1, 3, 1, 1, "def_dot_last_pulse_on");

        // UNIT_CYCLES = 4.
        play(1, 1'b1, 1'b0, 3, 1, 4, 0, "uc4_dash");
        play(1, 1'b0, 1'b1, 1, 3, 4, 0, "uc4_dot_last");

        // SYM_GAP_UNITS = 0: no GAP phase after a non-last symbol.
        play(2, 1'b0, 1'b0, 1, 0, 1, 0, "g0_dot");
        play(2, 1'b1, 1'b1, 3, 3, 1, 0, "g0_dash_last");

        // Back-to-back: dot (last=0) then, with sym_strt held, a dash (last=0)
        // accepted in the DONE cycle. Bit c of each vector is cycle c.
        e_led  = 10'b0001110010;
        e_busy = 10'b0011110110;
        e_done = 10'b0100001000;
        @(negedge clk);
        strt[0] = 1'b1;
        sym[0]  = 1'b0;
        last[0] = 1'b0;
        @(posedge clk);
        #1;
        sym[0] = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            chk($sformatf("b2b c%0d led", c),  int'(led_o[0]),  int'(e_led[c]));
            chk($sformatf("b2b c%0d busy", c), int'(busy_o[0]), int'(e_busy[c]));
            chk($sformatf("b2b c%0d done", c), int'(done_o[0]), int'(e_done[c]));
            if (c == 3) begin
                @(posedge clk);
                #1;
                strt[0] = 1'b0;
            end
        end
        $display("sym b2b: dot then dash with sym_strt held through DONE");

        // Asynchronous reset in the middle of a dash.
        @(negedge clk);
        strt[0] = 1'b1;
        sym[0]  = 1'b1;
        last[0] = 1'b1;
        @(posedge clk);
        #1;
        strt[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("arst pre led", int'(led_o[0]), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst led",  int'(led_o[0]),  0);
        chk("arst busy", int'(busy_o[0]), 0);
        chk("arst done", int'(done_o[0]), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk($sformatf("arst after c%0d done", c), int'(done_o[0]), 0);
            chk($sformatf("arst after c%0d busy", c), int'(busy_o[0]), 0);
        end
        $display("reset: asserted mid-dash between edges");
        play(0, 1'b0, 1'b0, 1, 1, 1, 0, "post_rst_dot");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
